// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared constants and state types for the AXI4-Lite SRAM
//                slave: response codes, channel FSM states, LFSR constants.
//  Revision    : 1.0  initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 with a left shift: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage
`default_nettype wire

// File: rtl/axil_sram_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr8
//  Description : Free-running 8-bit Fibonacci LFSR used to draw random
//                response latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr8
    import axil_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] lfsr_o
);

    // One shift per clock; feedback is the parity of the tapped bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_o <= LFSR_SEED;
        end else begin
            lfsr_o <= {lfsr_o[6:0], ^(lfsr_o & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_sram.sv
`default_nettype none
// ============================================================================
//  Module      : axil_sram
//  Description : AXI4-Lite slave backed by a word-organised register-file
//                SRAM. Independent read and write channels, each with a
//                fixed or pseudo-random response latency.
//  Revision    : 1.0  initial release
// ============================================================================
module axil_sram
    import axil_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE        = 32'h8000_0000,
    parameter int                LAT_FIXED   = 2,
    parameter int                LAT_RAND    = 0,
    parameter int                LAT_BITS    = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i
);

    localparam int c_strb_w = DATA_W / 8;
    localparam int c_idx_w  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_cnt_w  = 16;
    localparam logic [c_cnt_w-1:0] c_lat_fixed =
        (LAT_FIXED < 1) ? c_cnt_w'(1) : c_cnt_w'(LAT_FIXED);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE) && (((addr - BASE) >> 2) < ADDR_W'(DEPTH_WORDS));
    endfunction

    function automatic logic [c_idx_w-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return c_idx_w'((addr - BASE) >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Latency source
    // ------------------------------------------------------------------
    logic [7:0]         lfsr;
    logic [c_cnt_w-1:0] w_lat;
    logic               w_unused_lfsr;

    lfsr8 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lfsr_o (lfsr)
    );

    assign w_unused_lfsr = ^lfsr;

    generate
        if (LAT_RAND != 0) begin : g_lat_rand
            assign w_lat = c_cnt_w'(lfsr[LAT_BITS-1:0]) + c_cnt_w'(1);
        end else begin : g_lat_fixed
            assign w_lat = c_lat_fixed;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage (contents are deliberately not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e          r_rd_state;
    logic [ADDR_W-1:0]  r_araddr;
    logic [c_cnt_w-1:0] r_rcnt;
    logic               w_ar_hs;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_rd_ok;
    logic [DATA_W-1:0]  w_rd_word;

    assign w_ar_hs   = arvalid_i && arready_o;
    // A latency of one has no spare cycle for R_WAIT, so it samples the live address
    assign w_rd_addr = (r_rd_state == R_IDLE) ? araddr_i : r_araddr;
    assign w_rd_ok   = in_range(w_rd_addr);
    assign w_rd_word = w_rd_ok ? mem[word_idx(w_rd_addr)] : '0;

    // Read FSM: capture address, count down the latency, hold the response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_state <= R_IDLE;
            r_araddr   <= '0;
            r_rcnt     <= '0;
            arready_o  <= 1'b1;
            rvalid_o   <= 1'b0;
            rdata_o    <= '0;
            rresp_o    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr  <= araddr_i;
                        r_rcnt    <= w_lat;
                        arready_o <= 1'b0;
                        if (w_lat == c_cnt_w'(1)) begin
                            rdata_o    <= w_rd_word;
                            rresp_o    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                            rvalid_o   <= 1'b1;
                            r_rd_state <= R_RESP;
                        end else begin
                            r_rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    // Counter steps down to 1 on this edge: sample the word now
                    if (r_rcnt <= c_cnt_w'(2)) begin
                        rdata_o    <= w_rd_word;
                        rresp_o    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_o   <= 1'b1;
                        r_rd_state <= R_RESP;
                    end
                    r_rcnt <= r_rcnt - c_cnt_w'(1);
                end
                R_RESP: begin
                    if (rready_i) begin
                        rvalid_o   <= 1'b0;
                        arready_o  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                    arready_o  <= 1'b1;
                    rvalid_o   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e           r_wr_state;
    logic                r_aw_held;
    logic                r_w_held;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_strb_w-1:0] r_wstrb;
    logic [c_cnt_w-1:0]  r_wcnt;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_aw_now;
    logic                w_w_now;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [c_strb_w-1:0] w_wr_strb;
    logic                w_wr_ok;
    logic                w_wr_fire;

    assign w_aw_hs   = awvalid_i && awready_o;
    assign w_w_hs    = wvalid_i && wready_o;
    assign w_aw_now  = r_aw_held || w_aw_hs;
    assign w_w_now   = r_w_held || w_w_hs;
    // Held values win; the live bus only matters in the cycle of its handshake
    assign w_wr_addr = r_aw_held ? r_awaddr : awaddr_i;
    assign w_wr_data = r_w_held ? r_wdata : wdata_i;
    assign w_wr_strb = r_w_held ? r_wstrb : wstrb_i;
    assign w_wr_ok   = in_range(w_wr_addr);
    assign w_wr_fire = ((r_wr_state == W_IDLE) && w_aw_now && w_w_now &&
                        (w_lat == c_cnt_w'(1))) ||
                       ((r_wr_state == W_WAIT) && (r_wcnt <= c_cnt_w'(2)));

    // Write FSM: latch AW and W in any order, count down, then respond
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wcnt     <= '0;
            awready_o  <= 1'b1;
            wready_o   <= 1'b1;
            bvalid_o   <= 1'b0;
            bresp_o    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= awaddr_i;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= wdata_i;
                        r_wstrb  <= wstrb_i;
                        r_w_held <= 1'b1;
                    end
                    if (w_aw_now && w_w_now) begin
                        r_wcnt    <= w_lat;
                        awready_o <= 1'b0;
                        wready_o  <= 1'b0;
                        if (w_lat == c_cnt_w'(1)) begin
                            bvalid_o   <= 1'b1;
                            bresp_o    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_wr_state <= W_WAIT;
                        end
                    end else begin
                        awready_o <= !w_aw_now;
                        wready_o  <= !w_w_now;
                    end
                end
                W_WAIT: begin
                    if (r_wcnt <= c_cnt_w'(2)) begin
                        bvalid_o   <= 1'b1;
                        bresp_o    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= W_RESP;
                    end
                    r_wcnt <= r_wcnt - c_cnt_w'(1);
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_o   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        awready_o  <= 1'b1;
                        wready_o   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                    awready_o  <= 1'b1;
                    wready_o   <= 1'b1;
                    bvalid_o   <= 1'b0;
                end
            endcase
        end
    end

    // Byte-strobed commit; shares the edge with a read sample, so reads see old data
    always_ff @(posedge clk_i) begin
        if (w_wr_fire && w_wr_ok) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (w_wr_strb[b]) begin
                    mem[word_idx(w_wr_addr)][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_sram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_sram
//  Description : Directed self-checking bench for axil_sram. Two instances
//                (latency 2 and latency 4) share all stimulus; sel picks
//                which one's outputs are observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axil_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;

    logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
    logic [31:0] rdata_a;
    logic [1:0]  rresp_a, bresp_a;
    logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b;
    logic [31:0] rdata_b;
    logic [1:0]  rresp_b, bresp_b;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign arready = sel ? arready_b : arready_a;
    assign rvalid  = sel ? rvalid_b  : rvalid_a;
    assign awready = sel ? awready_b : awready_a;
    assign wready  = sel ? wready_b  : wready_a;
    assign bvalid  = sel ? bvalid_b  : bvalid_a;
    assign rdata   = sel ? rdata_b   : rdata_a;
    assign rresp   = sel ? rresp_b   : rresp_a;
    assign bresp   = sel ? bresp_b   : bresp_a;

    axil_sram #(.LAT_FIXED(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_a),
        .rdata_o(rdata_a), .rresp_o(rresp_a), .rvalid_o(rvalid_a), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_a),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_a),
        .bresp_o(bresp_a), .bvalid_o(bvalid_a), .bready_i(bready)
    );

    axil_sram #(.LAT_FIXED(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_b),
        .rdata_o(rdata_b), .rresp_o(rresp_b), .rvalid_o(rvalid_b), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_b),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_b),
        .bresp_o(bresp_b), .bvalid_o(bvalid_b), .bready_i(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; lat counts cycles from the later handshake to bvalid
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        bit aw_done, w_done, ah, wh;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            tick();
            n++;
            if (ah) begin awvalid = 1'b0; aw_done = 1; end
            if (wh) begin wvalid = 1'b0; w_done = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        resp = bresp;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    // Full read transaction; lat counts cycles from the AR handshake to rvalid
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        d = rdata; resp = rresp;
        rready = 1'b1; tick(); rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
        tick(); tick(); tick();
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            errors++; $display("FAIL reset_hs: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++;
        if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b want 00", rresp); end
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %b want 00", bresp); end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            errors++; $display("FAIL post_reset_hs: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b want 00", resp); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        do_read(32'h8000_0010, d, resp, lat);
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got %b want 00", resp); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h8000_0000, 32'h11223344, 4'hF, resp, lat);
        do_write(32'h8000_0000, 32'hAABBCCDD, 4'b0101, resp, lat);
        do_read(32'h8000_0000, d, resp, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h want 11bb33dd", d); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] d; int lat;
        awaddr = 32'h8000_0020; wdata = 32'h0BADF00D; wstrb = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if ({wready, awready} !== 2'b01) begin
            errors++; $display("FAIL w_first_ready: got %b want 01", {wready, awready});
        end
        tick(); tick();
        checks++;
        if ({wready, bvalid} !== 2'b00) begin
            errors++; $display("FAIL w_first_idle: got %b want 00", {wready, bvalid});
        end
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL w_first_latency: got %0d want 2", lat); end
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL w_first_bresp: got %b want 00", bresp); end
        bready = 1'b1; tick(); bready = 1'b0;
        do_read(32'h8000_0020, d, resp, lat);
        checks++;
        if (d !== 32'h0BADF00D) begin errors++; $display("FAIL w_first_data: got %h want 0badf00d", d); end
    endtask

    task automatic test_read_before_write();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h8000_0030, 32'h1111_1111, 4'hF, resp, lat);
        araddr = 32'h8000_0030; arvalid = 1'b1;
        awaddr = 32'h8000_0030; wdata = 32'h2222_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checks++;
        if ({rvalid, bvalid} !== 2'b11) begin errors++; $display("FAIL rbw_valids: got %b want 11", {rvalid, bvalid}); end
        checks++;
        if (rdata !== 32'h1111_1111) begin errors++; $display("FAIL rbw_old_data: got %h want 11111111", rdata); end
        rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0030, d, resp, lat);
        checks++;
        if (d !== 32'h2222_2222) begin errors++; $display("FAIL rbw_new_data: got %h want 22222222", d); end
    endtask

    task automatic test_backpressure();
        araddr = 32'h8000_0010; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rvalid, arready} !== 2'b10) begin
                errors++; $display("FAIL bp_hold_%0d: got %b want 10", i, {rvalid, arready});
            end
            checks++;
            if (rdata !== 32'hDEADBEEF) begin
                errors++; $display("FAIL bp_data_%0d: got %h want deadbeef", i, rdata);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got %b want 01", {rvalid, arready});
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_read(32'h7FFF_FFFC, d, resp, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_rresp: got %b want 10", resp); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", d); end
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b want 10", resp); end
        do_write(32'h8000_0FFC, 32'h1234_5678, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL top_word_bresp: got %b want 00", resp); end
        do_read(32'h8000_0FFC, d, resp, lat);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL top_word_data: got %h want 12345678", d); end
        do_read(32'h8000_0000, d, resp, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin errors++; $display("FAIL oor_word0: got %h want 11bb33dd", d); end
    endtask

    task automatic test_reset_wwait();
        logic [1:0] resp; logic [31:0] d; int lat;
        sel = 1'b1;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        do_write(32'h8000_0040, 32'h5555_5555, 4'hF, resp, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL l4_wr_latency: got %0d want 4", lat); end
        awaddr = 32'h8000_0040; wdata = 32'hAAAA_AAAA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            errors++; $display("FAIL rst_wwait_hs: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
        checks++;
        if ({rdata, rresp, bresp} !== 36'h0) begin
            errors++; $display("FAIL rst_wwait_regs: got %h want 0", {rdata, rresp, bresp});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h8000_0040, d, resp, lat);
        checks++;
        if (d !== 32'h5555_5555) begin errors++; $display("FAIL rst_wwait_data: got %h want 55555555", d); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL l4_rd_latency: got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_w_before_aw();
        test_read_before_write();
        test_backpressure();
        test_out_of_range();
        test_reset_wwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
